prbs_checker: RTL and testbench
===============================

// Module: prbs_checker
// PURPOSE
//  Receive-side checker for the on-chip 8-bit LFSR pattern generator (recurrence b[n] = b[n-7] ^ b[n-8]).
//  Takes one serial bit per valid cycle and self-synchronises to the pattern, from any starting phase.
//  Once synchronised, it counts bit errors and monitors loss of lock.
//  Sits at the loopback/far end of the link, behind the pad input stage; results are exported to the
//  status/readout logic.
// PARAMETERS
//  WIDTH        8    LFSR length; the receive shift register is this wide
//  TAP_A        7    first feedback tap (bit index)
//  TAP_B        6    second feedback tap (bit index)
//  VERIFY_LEN   16   consecutive correct predictions required to declare lock
//  WINDOW       64   lock-monitor window length, in valid bits
//  LOSS_THRESH  4    errors inside one window that force loss of lock
//  CNT_W        16   width of the error and bit counters
// PORTS
//  clk         in   1      single clock; all logic on its rising edge
//  rst_n       in   1      reset: synchronous and ACTIVE-HIGH (1 = reset)
//  din_valid   in   1      din is sampled only on edges where din_valid=1
//  din         in   1      received serial bit
//  clr_counts  in   1      synchronous clear of err_count and bit_count
//  locked      out  1      1 while the FSM is in LOCKED
//  err_pulse   out  1      one-cycle strobe: a counted mismatch was sampled on this edge
//  err_count   out  CNT_W  saturating count of mismatches seen while LOCKED
//  bit_count   out  CNT_W  saturating count of valid bits checked while LOCKED
//  sync_state  out  2      FSM state: 0=SEARCH, 1=VERIFY, 2=LOCKED
// BEHAVIOUR
//  Interface rule, fixed: one clock; reset is synchronous and active-high.
//  Reset (rst_n=1 at an edge):
//   - shift reg=0, all counters=0, FSM=SEARCH
//   - locked=0, err_pulse=0, err_count=0, bit_count=0, sync_state=0
//   - reset overrides every other input, including mid-lock
//  Prediction and shifting:
//   - expected = sr[TAP_A] ^ sr[TAP_B]
//   - on each valid edge, sr <= {sr[WIDTH-2:0], nb}
//   - nb = din in SEARCH and VERIFY; nb = expected in LOCKED (free-run, so a single flip is not smeared)
//  Edges with din_valid=0: no state, counter, or register changes; err_pulse=0.
//  SEARCH:
//   - fill_cnt counts valid bits
//   - after WIDTH valid bits, go to VERIFY; ver_cnt=0
//  VERIFY:
//   - each valid bit: if din==expected and sr!=0, ver_cnt++
//   - otherwise go to SEARCH; fill_cnt=0
//   - the all-zero register is never lockable
//   - when the VERIFY_LEN-th consecutive match is sampled, go to LOCKED on that same edge
//   - win_cnt=0 and win_err=0 on entry
//  LOCKED:
//   - each valid bit: bit_count++ (saturate at 2^CNT_W-1)
//   - if din!=expected: err_pulse=1 that cycle, err_count++ (saturate), win_err++
//   - win_cnt counts 0..WINDOW-1; on the bit where win_cnt==WINDOW-1, both win_cnt and win_err reset
//   - when win_err would reach LOSS_THRESH: go to SEARCH on that edge; locked=0 from that edge;
//     fill_cnt=0; err_count/bit_count keep their values
//  Outputs are registered: they reflect the bit sampled at the preceding edge.
//  Lock latency from reset release with a clean stream: WIDTH+VERIFY_LEN valid bits (24 by default).
//  clr_counts:
//   - zeroes err_count and bit_count on that edge
//   - has priority over an increment on the same edge; that bit is not counted
//   - err_pulse still fires for it
//   - does not affect FSM, window counters, or lock
//  Both counters saturate and do not wrap; err_count<=bit_count always holds.
// TESTING
//  T1 Reset: rst_n=1 for 3 edges, random din -> all outputs 0, sync_state=0.
//  T2 Clean lock:
//   - stimulus: reference LFSR seeded 8'h01, entered at an arbitrary phase, din_valid=1
//   - response: locked=1 exactly after the 24th bit; then 1000 bits -> err_count=0, bit_count=1000
//  T3 Single flip: invert one bit while locked -> one err_pulse, err_count=1, locked stays 1,
//     no further errors (free-run check).
//  T4 Loss and relock:
//   - stimulus: 4 flips within 64 bits
//   - response: locked=0 on the 4th flip; relock 24 bits later; err_count=4 retained
//  T5 Gaps and zeros:
//   - din_valid toggled randomly 50% -> same result as T2, counting valid bits only
//   - an all-zero stream -> never leaves SEARCH/VERIFY
//  T6 Saturation and clear:
//   - CNT_W=4 with a continuous error stream -> err_count holds at 15
//   - clr_counts asserted on an error bit -> counts=0, err_pulse=1
//   - rst_n pulsed mid-lock -> SEARCH with all counters 0

Source files
------------

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising PRBS receive checker with lock monitor and error counters
module prbs_checker #(
    parameter int WIDTH       = 8,
    parameter int TAP_A       = 7,
    parameter int TAP_B       = 6,
    parameter int VERIFY_LEN  = 16,
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clr_counts,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count,
    output logic [1:0]       sync_state
);
    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam int VER_W  = $clog2(VERIFY_LEN + 1);
    localparam int WIN_W  = $clog2(WINDOW + 1);
    localparam int WERR_W = $clog2(LOSS_THRESH + 1);

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);
    localparam logic [VER_W-1:0]  VER_LAST  = VER_W'(VERIFY_LEN - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [WERR_W-1:0] LOSS_LAST = WERR_W'(LOSS_THRESH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [FILL_W-1:0]  fill_cnt_q, fill_cnt_d;
    logic [VER_W-1:0]   ver_cnt_q, ver_cnt_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]  win_err_q, win_err_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic [CNT_W-1:0]   bit_count_q, bit_count_d;
    logic               err_pulse_q, err_pulse_d;
    logic               expected;
    logic               mismatch;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_cnt_d  = fill_cnt_q;
        ver_cnt_d   = ver_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_count_d = err_count_q;
        bit_count_d = bit_count_q;
        err_pulse_d = 1'b0;
        expected    = sr_q[TAP_A] ^ sr_q[TAP_B];
        mismatch    = din ^ expected;

        if (din_valid) begin
            case (state_q)
                ST_SEARCH: begin
                    sr_d = {sr_q[WIDTH-2:0], din};
                    if (fill_cnt_q == FILL_LAST) begin
                        state_d   = ST_VERIFY;
                        ver_cnt_d = '0;
                    end else begin
                        fill_cnt_d = fill_cnt_q + FILL_W'(1);
                    end
                end
                ST_VERIFY: begin
                    sr_d = {sr_q[WIDTH-2:0], din};
                    // An all-zero register predicts zeros forever, so it must never count as a match.
                    if (!mismatch && (sr_q != '0)) begin
                        if (ver_cnt_q == VER_LAST) begin
                            state_d   = ST_LOCKED;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end else begin
                            ver_cnt_d = ver_cnt_q + VER_W'(1);
                        end
                    end else begin
                        state_d    = ST_SEARCH;
                        fill_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    // Free-run on the prediction so a single received flip is counted once.
                    sr_d = {sr_q[WIDTH-2:0], expected};
                    if (bit_count_q != CNT_MAX) begin
                        bit_count_d = bit_count_q + CNT_W'(1);
                    end
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != CNT_MAX) begin
                            err_count_d = err_count_q + CNT_W'(1);
                        end
                    end
                    if (mismatch && (win_err_q == LOSS_LAST)) begin
                        state_d    = ST_SEARCH;
                        fill_cnt_d = '0;
                    end else if (win_cnt_q == WIN_LAST) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                        if (mismatch) begin
                            win_err_d = win_err_q + WERR_W'(1);
                        end
                    end
                end
                default: begin
                    state_d    = ST_SEARCH;
                    fill_cnt_d = '0;
                end
            endcase
        end

        if (clr_counts) begin
            err_count_d = '0;
            bit_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= ST_SEARCH;
            sr_q        <= '0;
            fill_cnt_q  <= '0;
            ver_cnt_q   <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_count_q <= '0;
            bit_count_q <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_cnt_q  <= fill_cnt_d;
            ver_cnt_q   <= ver_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_count_q <= err_count_d;
            bit_count_q <= bit_count_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign locked     = (state_q == ST_LOCKED);
    assign err_pulse  = err_pulse_q;
    assign err_count  = err_count_q;
    assign bit_count  = bit_count_q;
    assign sync_state = state_q;
endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - self-checking bench for prbs_checker (reset table plus scoreboarded scenarios)
module tb_prbs_checker;
    typedef struct {
        logic        rst;
        logic        valid;
        logic        din;
        logic        clr;
        logic [1:0]  st;
        logic        lk;
        logic        ep;
        logic [15:0] ec;
        logic [15:0] bc;
    } vec_t;

    typedef struct {
        logic [1:0]  st;
        logic        lk;
        logic        ep;
        logic [15:0] ec;
        logic [15:0] bc;
        logic [3:0]  sec;
        logic [3:0]  sbc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        din_valid = 1'b0;
    logic        din = 1'b0;
    logic        clr_counts = 1'b0;
    logic        locked, err_pulse;
    logic [15:0] err_count, bit_count;
    logic [1:0]  sync_state;
    logic        sat_locked, sat_err_pulse;
    logic [3:0]  sat_err_count, sat_bit_count;
    logic [1:0]  sat_sync_state;

    int n_vec = 0;
    int n_bad = 0;
    int pulse_cnt = 0;
    string phase = "init";
    exp_t sb_q[$];
    vec_t tbl[15];

    logic [7:0] g;
    logic [7:0] m_sr;
    int m_state, m_fill, m_ver, m_wcnt, m_werr, m_err, m_bit;
    logic m_pulse;

    prbs_checker u_dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr_counts(clr_counts),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count),
        .sync_state(sync_state)
    );

    prbs_checker #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr_counts(clr_counts),
        .locked(sat_locked), .err_pulse(sat_err_pulse), .err_count(sat_err_count),
        .bit_count(sat_bit_count), .sync_state(sat_sync_state)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_ref(output logic b);
        b = g[7] ^ g[6];
        g = {g[6:0], b};
    endtask

    task automatic seed_ref();
        logic b;
        g = 8'h01;
        repeat ($urandom_range(0, 254)) next_ref(b);
    endtask

    task automatic model_reset();
        m_sr = 8'h00; m_state = 0; m_fill = 0; m_ver = 0;
        m_wcnt = 0; m_werr = 0; m_err = 0; m_bit = 0; m_pulse = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic d, input logic c);
        logic pred, miss;
        m_pulse = 1'b0;
        if (v) begin
            pred = m_sr[7] ^ m_sr[6];
            miss = d ^ pred;
            case (m_state)
                0: begin
                    m_sr = {m_sr[6:0], d};
                    m_fill++;
                    if (m_fill == 8) begin m_state = 1; m_ver = 0; end
                end
                1: begin
                    if (!miss && m_sr != 8'h00) begin
                        m_ver++;
                        if (m_ver == 16) begin m_state = 2; m_wcnt = 0; m_werr = 0; end
                    end else begin
                        m_state = 0; m_fill = 0;
                    end
                    m_sr = {m_sr[6:0], d};
                end
                default: begin
                    m_sr = {m_sr[6:0], pred};
                    if (m_bit < 65535) m_bit++;
                    if (miss) begin
                        m_pulse = 1'b1;
                        if (m_err < 65535) m_err++;
                        m_werr++;
                    end
                    if (m_werr == 4) begin m_state = 0; m_fill = 0; end
                    else if (m_wcnt == 63) begin m_wcnt = 0; m_werr = 0; end
                    else m_wcnt++;
                end
            endcase
        end
        if (c) begin m_err = 0; m_bit = 0; end
    endtask

    task automatic apply(input logic r, input logic v, input logic d, input logic c);
        exp_t e;
        exp_t w;
        rst_n = r; din_valid = v; din = d; clr_counts = c;
        if (r) model_reset(); else model_step(v, d, c);
        e.st  = 2'(m_state);
        e.lk  = (m_state == 2);
        e.ep  = m_pulse;
        e.ec  = 16'(m_err);
        e.bc  = 16'(m_bit);
        e.sec = (m_err > 15) ? 4'hF : 4'(m_err);
        e.sbc = (m_bit > 15) ? 4'hF : 4'(m_bit);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        w = sb_q.pop_front();
        n_vec++;
        if (sync_state !== w.st || locked !== w.lk || err_pulse !== w.ep || err_count !== w.ec ||
            bit_count !== w.bc || sat_sync_state !== w.st || sat_locked !== w.lk ||
            sat_err_pulse !== w.ep || sat_err_count !== w.sec || sat_bit_count !== w.sbc) begin
            n_bad++;
            $display("FAIL sb_%0s: got st=%0d lk=%0b ep=%0b ec=%0d bc=%0d sec=%0d sbc=%0d want st=%0d lk=%0b ep=%0b ec=%0d bc=%0d sec=%0d sbc=%0d",
                     phase, sync_state, locked, err_pulse, err_count, bit_count, sat_err_count,
                     sat_bit_count, w.st, w.lk, w.ep, w.ec, w.bc, w.sec, w.sbc);
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %0s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic clean(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            next_ref(b);
            apply(1'b0, 1'b1, b, 1'b0);
            if (err_pulse === 1'b1) pulse_cnt++;
        end
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b1, 1'($urandom), 1'b0);
        apply(1'b1, 1'b0, 1'($urandom), 1'b1);
    endtask

    task automatic run_until_lock(input bit rnd, output int nvalid);
        logic v, b;
        int cnt = 0;
        nvalid = 0;
        for (int i = 0; i < 400; i++) begin
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (v) begin next_ref(b); cnt++; end
            else b = 1'($urandom);
            apply(1'b0, v, b, 1'b0);
            if (locked === 1'b1) begin nvalid = cnt; break; end
        end
    endtask

    initial begin
        int idx, nv, vcount, seen;
        logic b, v;

        // Reset, fill and the first VERIFY decision, with fixed expectations.
        idx = 0;
        tbl[idx++] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[idx++] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[idx++] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[idx++] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0};
        for (int i = 0; i < 7; i++)
            tbl[idx++] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[idx++] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[idx++] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[idx++] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[idx++] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0};

        for (int i = 0; i < 15; i++) begin
            rst_n = tbl[i].rst; din_valid = tbl[i].valid; din = tbl[i].din; clr_counts = tbl[i].clr;
            @(posedge clk);
            #1;
            n_vec++;
            if (sync_state !== tbl[i].st || locked !== tbl[i].lk || err_pulse !== tbl[i].ep ||
                err_count !== tbl[i].ec || bit_count !== tbl[i].bc) begin
                n_bad++;
                $display("FAIL tbl[%0d]: got st=%0d lk=%0b ep=%0b ec=%0d bc=%0d want st=%0d lk=%0b ep=%0b ec=%0d bc=%0d",
                         i, sync_state, locked, err_pulse, err_count, bit_count,
                         tbl[i].st, tbl[i].lk, tbl[i].ep, tbl[i].ec, tbl[i].bc);
            end
        end

        phase = "t2";
        do_reset();
        seed_ref();
        run_until_lock(1'b0, nv);
        check("t2_lock_latency", nv, 24);
        clean(1000);
        check("t2_err_count", int'(err_count), 0);
        check("t2_bit_count", int'(bit_count), 1000);

        phase = "t3";
        pulse_cnt = 0;
        next_ref(b);
        apply(1'b0, 1'b1, ~b, 1'b0);
        if (err_pulse === 1'b1) pulse_cnt++;
        clean(200);
        check("t3_pulses", pulse_cnt, 1);
        check("t3_err_count", int'(err_count), 1);
        check("t3_locked", int'(locked), 1);

        phase = "t4";
        next_ref(b);
        apply(1'b0, 1'b1, b, 1'b1);
        for (int i = 0; i < 64 && m_wcnt != 0; i++) clean(1);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) check("t4_locked_before_4th", int'(locked), 1);
            next_ref(b);
            apply(1'b0, 1'b1, ~b, 1'b0);
            if (k < 3) clean(4);
        end
        check("t4_unlock_on_4th", int'(locked), 0);
        run_until_lock(1'b0, nv);
        check("t4_relock_latency", nv, 24);
        check("t4_err_retained", int'(err_count), 4);

        phase = "t5";
        do_reset();
        seed_ref();
        run_until_lock(1'b1, nv);
        check("t5_gap_lock_latency", nv, 24);
        vcount = 0;
        for (int i = 0; i < 5000 && vcount < 1000; i++) begin
            v = 1'($urandom_range(0, 1));
            if (v) begin next_ref(b); vcount++; end
            else b = 1'($urandom);
            apply(1'b0, v, b, 1'b0);
        end
        check("t5_gap_bit_count", int'(bit_count), 1000);
        check("t5_gap_err_count", int'(err_count), 0);
        do_reset();
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0);
            if (locked !== 1'b0 || sync_state === 2'd2) seen = 1;
        end
        check("t5_zero_never_locks", seen, 0);

        phase = "t6";
        do_reset();
        seed_ref();
        run_until_lock(1'b0, nv);
        check("t6_lock_latency", nv, 24);
        for (int j = 0; j < 640; j++) begin
            next_ref(b);
            apply(1'b0, 1'b1, b ^ ((j % 32) == 10), 1'b0);
        end
        check("t6_sat_err_count", int'(sat_err_count), 15);
        check("t6_sat_bit_count", int'(sat_bit_count), 15);
        check("t6_err_count", int'(err_count), 20);
        check("t6_bit_count", int'(bit_count), 640);
        check("t6_still_locked", int'(locked), 1);
        next_ref(b);
        apply(1'b0, 1'b1, ~b, 1'b1);
        check("t6_clr_pulse", int'(err_pulse), 1);
        check("t6_clr_err", int'(err_count), 0);
        check("t6_clr_bits", int'(bit_count), 0);
        clean(5);
        apply(1'b1, 1'b1, 1'($urandom), 1'b0);
        check("t6_rst_state", int'(sync_state), 0);
        check("t6_rst_locked", int'(locked), 0);
        check("t6_rst_counts", int'(err_count) + int'(bit_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
